green_bullet_collision: RTL and testbench
=========================================

GREEN_BULLET_COLLISION -- requirements
Module: green_bullet_collision

Interface
REQ-001 Parameter HP_MAX, default 20, upper saturation limit of hp.
REQ-002 Parameter HP_INIT, default 10, value of hp after reset.
REQ-003 Parameter HEAL_AMOUNT, default 5, hp increment per green-bullet hit.
REQ-004 Parameter RESPAWN_FRAMES, default 60, frame ends spent hidden after a hit (legal range 1..255).
REQ-005 Pclk  input  1  25MHz pixel clock; sole clock, all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 xx  input  10  current pixel x position from the VGA timing generator.
REQ-008 yy  input  10  current pixel y position from the VGA timing generator.
REQ-009 aactive  input  1  high during active pixel drawing.
REQ-010 HeartSpriteOn  input  1  player heart sprite covers current pixel.
REQ-011 GreenBulletSpriteOn  input  1  green bullet sprite covers current pixel (registered by the bullet sprite stage).
REQ-012 isCollisionGB  output  1  high while the green bullet is consumed and hidden; fed back to the bullet sprite stage.
REQ-013 hp  output  8  current player hit points.
REQ-014 heal_pulse  output  1  single-cycle strobe on each accepted hit.
REQ-015 hit_count  output  8  accepted green-bullet hits since reset, saturating at 255.

Function
REQ-016 Frame end SHALL be the cycle with xx==639 and yy==479.
REQ-017 Overlap SHALL be aactive && HeartSpriteOn && GreenBulletSpriteOn in the same cycle; overlap with aactive low SHALL be ignored.
REQ-018 State machine SHALL have two states: ARMED (bullet visible, detecting) and HIDDEN (bullet consumed, counting frames).
REQ-019 In ARMED, overlap SHALL move the state to HIDDEN on the next rising edge.
REQ-020 On the ARMED->HIDDEN edge: isCollisionGB SHALL go 1, heal_pulse SHALL be 1 for exactly one cycle, hp SHALL become min(hp+HEAL_AMOUNT, HP_MAX), hit_count SHALL increment unless already 255, frame counter SHALL clear to 0.
REQ-021 hp arithmetic SHALL be computed at 9 bits before saturation so no wrap occurs for any hp<=255.
REQ-022 In HIDDEN, overlap SHALL be ignored (no heal, no second pulse).
REQ-023 In HIDDEN, each frame end SHALL increment the frame counter; the frame end that makes the count equal RESPAWN_FRAMES SHALL move the state to ARMED, drive isCollisionGB to 0 and clear the counter on that edge.
REQ-024 Overlap coinciding with a frame end in ARMED SHALL be accepted as a hit; that frame end SHALL NOT be counted.
REQ-025 Frame ends in ARMED SHALL have no effect.
REQ-026 isCollisionGB SHALL equal (state==HIDDEN) and be driven from a register, no combinational path from inputs.
REQ-027 hp SHALL change only on accepted hits; hit_count SHALL never wrap.

Reset
REQ-028 While rst is high, asynchronously: state ARMED, isCollisionGB 0, heal_pulse 0, hp HP_INIT, hit_count 0, frame counter 0.
REQ-029 Reset asserted mid-HIDDEN or during a heal_pulse cycle SHALL abort it immediately; first cycle after release is ARMED with no pending hit.

Verification
REQ-030 Reset release, no overlap for 3 frames -> hp=10, isCollisionGB=0, hit_count=0, heal_pulse never high.
REQ-031 One overlap pixel (aactive=1) with hp=10 -> next edge isCollisionGB=1, heal_pulse high one cycle, hp=15, hit_count=1; after 60 frame ends isCollisionGB=0.
REQ-032 hp=18, overlap -> hp=20 (saturated); further overlaps during HIDDEN -> hp stays 20, hit_count unchanged.
REQ-033 Overlap with aactive=0 -> no state change, hp unchanged; overlap on xx=639,yy=479 with aactive=1 -> hit accepted, respawn after 60 further frame ends.
REQ-034 rst pulsed at frame 30 of HIDDEN with hp=15 -> isCollisionGB=0 and hp=10 asynchronously, hit_count=0; next overlap accepted normally.
REQ-035 256 hits with RESPAWN_FRAMES=1 -> hit_count holds 255, hp holds 20.

Source files
------------

// File: rtl/green_bullet_collision.sv
// green_bullet_collision: heal the player when the heart overlaps the green bullet, then hide the bullet for a number of frames
//   Pclk                 pixel clock, all state on its rising edge
//   rst                  asynchronous active-high reset
//   xx, yy               current pixel position from the VGA timing generator
//   aactive              high during active pixel drawing
//   HeartSpriteOn        heart sprite covers current pixel
//   GreenBulletSpriteOn  green bullet sprite covers current pixel
//   isCollisionGB        high while the bullet is consumed and hidden
//   hp                   current player hit points
//   heal_pulse           one-cycle strobe per accepted hit
//   hit_count            accepted hits since reset, saturating at 255
module green_bullet_collision #(
    parameter int HP_MAX         = 20,
    parameter int HP_INIT        = 10,
    parameter int HEAL_AMOUNT    = 5,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       Pclk,
    input  logic       rst,
    input  logic [9:0] xx,
    input  logic [9:0] yy,
    input  logic       aactive,
    input  logic       HeartSpriteOn,
    input  logic       GreenBulletSpriteOn,
    output logic       isCollisionGB,
    output logic [7:0] hp,
    output logic       heal_pulse,
    output logic [7:0] hit_count
);
    typedef enum logic {ARMED, HIDDEN} state_t;
    state_t     state, state_nx;
    logic [7:0] frames, frames_nx, hp_nx, hit_count_nx;
    logic       heal_nx;
    logic       frame_end, overlap;
    logic [8:0] hp_sum;
    assign frame_end = (xx == 10'd639) && (yy == 10'd479);
    assign overlap   = aactive && HeartSpriteOn && GreenBulletSpriteOn;
    // nine bits so a large hp plus the heal cannot wrap before saturation
    assign hp_sum    = {1'b0, hp} + 9'(HEAL_AMOUNT);
    assign isCollisionGB = (state == HIDDEN);
    always_comb begin
        state_nx     = state;
        frames_nx    = frames;
        hp_nx        = hp;
        hit_count_nx = hit_count;
        heal_nx      = 1'b0;
        if (state == ARMED) begin
            if (overlap) begin
                state_nx     = HIDDEN;
                heal_nx      = 1'b1;
                hp_nx        = (hp_sum > 9'(HP_MAX)) ? 8'(HP_MAX) : hp_sum[7:0];
                hit_count_nx = (hit_count == 8'hff) ? hit_count : hit_count + 8'd1;
                frames_nx    = 8'd0;
            end
        end else if (frame_end) begin
            if ({1'b0, frames} + 9'd1 == 9'(RESPAWN_FRAMES)) begin
                state_nx  = ARMED;
                frames_nx = 8'd0;
            end else begin
                frames_nx = frames + 8'd1;
            end
        end
    end
    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            state      <= ARMED;
            frames     <= 8'd0;
            hp         <= 8'(HP_INIT);
            hit_count  <= 8'd0;
            heal_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            frames     <= frames_nx;
            hp         <= hp_nx;
            hit_count  <= hit_count_nx;
            heal_pulse <= heal_nx;
        end
    end
endmodule

// File: tb/tb_green_bullet_collision.sv
// tb_green_bullet_collision: directed scoreboard bench for green_bullet_collision
module tb_green_bullet_collision;
    localparam int HPMAX = 20, HPINIT = 10, HEAL = 5, RF = 60;
    logic       Pclk = 0, rst = 1;
    logic [9:0] xx = 0, yy = 0;
    logic       aactive = 0, HeartSpriteOn = 0, GreenBulletSpriteOn = 0;
    logic       isCollisionGB, heal_pulse;
    logic [7:0] hp, hit_count;
    int errors = 0, checks = 0;
    int m_hidden, m_pulse, m_hp, m_hit, m_frames;
    typedef struct {int isc; int pulse; int hp; int hit;} exp_t;
    exp_t sb[$];

    green_bullet_collision #(.HP_MAX(HPMAX), .HP_INIT(HPINIT), .HEAL_AMOUNT(HEAL), .RESPAWN_FRAMES(RF)) dut (
        .Pclk(Pclk), .rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
        .HeartSpriteOn(HeartSpriteOn), .GreenBulletSpriteOn(GreenBulletSpriteOn),
        .isCollisionGB(isCollisionGB), .hp(hp), .heal_pulse(heal_pulse), .hit_count(hit_count)
    );

    always #20 Pclk = ~Pclk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hidden = 0; m_pulse = 0; m_hp = HPINIT; m_hit = 0; m_frames = 0;
        sb.delete();
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++; checks++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".isc"}, {8'd0, isCollisionGB}, 9'(e.isc));
            chk({tag, ".pulse"}, {8'd0, heal_pulse}, 9'(e.pulse));
            chk({tag, ".hp"}, {1'b0, hp}, 9'(e.hp));
            chk({tag, ".hit"}, {1'b0, hit_count}, 9'(e.hit));
        end
    endtask

    task automatic step(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic a, input logic h, input logic g);
        xx = x; yy = y; aactive = a; HeartSpriteOn = h; GreenBulletSpriteOn = g;
        m_pulse = 0;
        if (m_hidden == 0) begin
            if (a && h && g) begin
                m_hidden = 1; m_pulse = 1; m_frames = 0;
                m_hp = (m_hp + HEAL > HPMAX) ? HPMAX : m_hp + HEAL;
                if (m_hit < 255) m_hit++;
            end
        end else if (x == 639 && y == 479) begin
            m_frames++;
            if (m_frames == RF) begin m_hidden = 0; m_frames = 0; end
        end
        sb.push_back('{m_hidden, m_pulse, m_hp, m_hit});
        @(posedge Pclk); #1;
        check_sb(tag);
    endtask

    task automatic idle(input string tag);  step(tag, 10'd100, 10'd100, 1'b1, 1'b1, 1'b0); endtask
    task automatic frame(input string tag); step(tag, 10'd639, 10'd479, 1'b0, 1'b0, 1'b0); endtask
    task automatic hit(input string tag);   step(tag, 10'd320, 10'd240, 1'b1, 1'b1, 1'b1); endtask

    task automatic async_reset(input string tag);
        #5 rst = 1; #1;
        chk({tag, ".isc"}, {8'd0, isCollisionGB}, 9'd0);
        chk({tag, ".pulse"}, {8'd0, heal_pulse}, 9'd0);
        chk({tag, ".hp"}, {1'b0, hp}, 9'(HPINIT));
        chk({tag, ".hit"}, {1'b0, hit_count}, 9'd0);
        model_reset();
        @(posedge Pclk); #1 rst = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Pclk);
        #1;
        chk("reset.isc", {8'd0, isCollisionGB}, 9'd0);
        chk("reset.hp", {1'b0, hp}, 9'(HPINIT));
        chk("reset.hit", {1'b0, hit_count}, 9'd0);
        chk("reset.pulse", {8'd0, heal_pulse}, 9'd0);
        rst = 0;
        repeat (3) begin idle("noov"); frame("noov_fe"); end
        chk("noov.hp", {1'b0, hp}, 9'd10);
        hit("hit1");
        chk("hit1.hp", {1'b0, hp}, 9'd15);
        chk("hit1.pulse", {8'd0, heal_pulse}, 9'd1);
        idle("hit1_after");
        chk("hit1.pulse_once", {8'd0, heal_pulse}, 9'd0);
        repeat (RF - 1) frame("respawn1");
        chk("respawn1.still_hidden", {8'd0, isCollisionGB}, 9'd1);
        frame("respawn1_last");
        chk("respawn1.armed", {8'd0, isCollisionGB}, 9'd0);
        hit("hit2");
        chk("hit2.hp", {1'b0, hp}, 9'd20);
        repeat (RF) frame("respawn2");
        hit("sat");
        chk("sat.hp", {1'b0, hp}, 9'd20);
        chk("sat.hit", {1'b0, hit_count}, 9'd3);
        repeat (5) hit("hidden_ov");
        chk("hidden_ov.hit", {1'b0, hit_count}, 9'd3);
        repeat (RF) frame("respawn3");
        step("inactive_ov", 10'd320, 10'd240, 1'b0, 1'b1, 1'b1);
        chk("inactive_ov.isc", {8'd0, isCollisionGB}, 9'd0);
        step("fe_ov", 10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
        chk("fe_ov.isc", {8'd0, isCollisionGB}, 9'd1);
        repeat (RF - 1) frame("fe_ov_respawn");
        chk("fe_ov.still_hidden", {8'd0, isCollisionGB}, 9'd1);
        frame("fe_ov_last");
        chk("fe_ov.armed", {8'd0, isCollisionGB}, 9'd0);
        async_reset("rst0");
        hit("pre_rst");
        repeat (30) frame("mid_hidden");
        chk("mid_hidden.hp", {1'b0, hp}, 9'd15);
        async_reset("rst_hidden");
        hit("post_rst");
        chk("post_rst.hp", {1'b0, hp}, 9'd15);
        async_reset("rst_pulse");
        idle("post_pulse_rst");
        repeat (256) begin
            hit("many");
            repeat (RF) frame("many_fe");
        end
        chk("many.hit", {1'b0, hit_count}, 9'd255);
        chk("many.hp", {1'b0, hp}, 9'd20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
